dmem_sram_ctrl: RTL and testbench

DMEM_SRAM_CTRL -- requirements
Module: dmem_sram_ctrl

---
 rtl/arm_mem_pkg.sv | 20 ++
 rtl/dmem_sram_ctrl.sv | 118 +++++++++++
 tb/tb_dmem_sram_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/arm_mem_pkg.sv
// Shared data-memory constants: controller state encoding, SRAM geometry and
// the byte base of data memory used when address rebasing is enabled.
package arm_mem_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  // Byte address at which data memory starts in the CPU address map.
  localparam logic [31:0] DMEM_BASE = 32'd1024;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } mem_state_e;

endpackage

// File: rtl/dmem_sram_ctrl.sv
// Data-memory controller: turns one 32-bit load/store from the MEM stage into
// two 16-bit SRAM half-word phases (low half first), each held WAIT_CYCLES
// cycles, and stalls the pipeline through ready until the access is done.
// Optional build macro: DMEM_BASE_OFFSET_EN rebases addresses so that byte
// 1024 of the CPU map is SRAM half-word 0.
module dmem_sram_ctrl
  import arm_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_r_en,
  input  logic                 mem_w_en,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 ready,
  output logic [SRAM_AW-1:0]   sram_addr,
  inout  wire  [SRAM_DW-1:0]   sram_dq,
  output logic                 sram_we_n,
  output logic                 sram_oe_n
);

  localparam logic [3:0] RELOAD = 4'(WAIT_CYCLES - 1);

  mem_state_e          state, nxt;
  logic [3:0]          cnt;
  logic                last;
  logic                req;
  logic [31:0]         eff_addr;
  logic [16:0]         widx;
  logic                drive;
  logic [SRAM_DW-1:0]  dout;
  logic                unused_addr_bits;

`ifdef DMEM_BASE_OFFSET_EN
  assign eff_addr = addr - DMEM_BASE;
`else
  assign eff_addr = addr;
`endif

  // Byte lane bits and bits above the SRAM range are intentionally dropped.
  assign widx             = eff_addr[18:2];
  assign unused_addr_bits = ^{eff_addr[31:19], eff_addr[1:0]};

  assign req  = mem_r_en | mem_w_en;
  assign last = (cnt == 4'd0);

  // State register, per-phase wait counter and load data capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rdata <= 32'd0;
    end else begin
      state <= nxt;
      // Reload on every state change so each phase gets a full WAIT_CYCLES.
      if (nxt != state)
        cnt <= RELOAD;
      else if (cnt != 4'd0)
        cnt <= cnt - 4'd1;
      if (state == RD_LO && last) rdata[15:0]  <= sram_dq;
      if (state == RD_HI && last) rdata[31:16] <= sram_dq;
    end
  end

  // Next state plus all SRAM-side and pipeline-side outputs.
  always_comb begin
    nxt       = state;
    ready     = 1'b0;
    sram_addr = '0;
    sram_we_n = 1'b1;
    sram_oe_n = 1'b1;
    drive     = 1'b0;
    dout      = '0;
    case (state)
      IDLE: begin
        ready = ~req;
        // A store wins if both enables are raised together.
        if (mem_w_en)      nxt = WR_LO;
        else if (mem_r_en) nxt = RD_LO;
      end
      RD_LO: begin
        sram_addr = {widx, 1'b0};
        sram_oe_n = 1'b0;
        if (last) nxt = RD_HI;
      end
      RD_HI: begin
        sram_addr = {widx, 1'b1};
        sram_oe_n = 1'b0;
        if (last) nxt = DONE;
      end
      WR_LO: begin
        sram_addr = {widx, 1'b0};
        sram_we_n = 1'b0;
        drive     = 1'b1;
        dout      = wdata[15:0];
        if (last) nxt = WR_HI;
      end
      WR_HI: begin
        sram_addr = {widx, 1'b1};
        sram_we_n = 1'b0;
        drive     = 1'b1;
        dout      = wdata[31:16];
        if (last) nxt = DONE;
      end
      DONE: begin
        ready = 1'b1;
        nxt   = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign sram_dq = drive ? dout : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_dmem_sram_ctrl.sv
// Directed bench for dmem_sram_ctrl with a behavioural async SRAM on the bus.
module tb_dmem_sram_ctrl;

  localparam int W = 2;
`ifdef DMEM_BASE_OFFSET_EN
  localparam logic [31:0] OFF = 32'd1024;
`else
  localparam logic [31:0] OFF = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] addr, wdata, rdata;
  logic        ready;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_we_n, sram_oe_n;

  logic [15:0] mem [0:(1<<18)-1];

  int tests = 0;
  int fails = 0;

  dmem_sram_ctrl #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
    .sram_addr(sram_addr), .sram_dq(sram_dq),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  always #5 clk = ~clk;

  // SRAM model: drives the bus while output-enabled, writes on clock while strobed.
  assign sram_dq = (!sram_oe_n) ? mem[sram_addr] : 16'bz;
  always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_dq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] widx(input logic [31:0] a);
    logic [31:0] e;
    e = a - OFF;
    return e[18:2];
  endfunction

  // Present one request and watch it through to DONE; returns at the DONE sample.
  task automatic run_access(input logic w, input logic r, input logic [31:0] a,
                            input logic [31:0] wd, input logic keep,
                            output int low, output int lo_n, output int hi_n,
                            output logic [17:0] lo_a, output logic [17:0] hi_a,
                            output logic oe_bad, output logic [31:0] rd);
    bit done = 0;
    mem_w_en = w; mem_r_en = r; addr = a; wdata = wd;
    low = 0; lo_n = 0; hi_n = 0; lo_a = '0; hi_a = '0; oe_bad = 0; rd = '0;
    #1;
    for (int c = 0; c < 60 && !done; c++) begin
      if (!ready) low++;
      if (!sram_oe_n || !sram_we_n) begin
        if (!sram_addr[0]) begin lo_n++; lo_a = sram_addr; end
        else               begin hi_n++; hi_a = sram_addr; end
      end
      if (w && !sram_oe_n) oe_bad = 1;
      if (ready && low > 0) begin
        done = 1;
        rd = rdata;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) chk("access_timeout", 32'd0, 32'd1);
    if (!keep) begin mem_w_en = 0; mem_r_en = 0; end
  endtask

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tv [5];

  initial begin
    int low, lo_n, hi_n;
    logic [17:0] lo_a, hi_a;
    logic oe_bad;
    logic [31:0] rd, saved;
    logic [16:0] wi;
    bit hit;

    tv[0] = '{1'b0, 1'b1, 32'h0000_0408, 32'h0,          32'hDEAD_BEEF};
    tv[1] = '{1'b1, 1'b0, 32'h0000_040C, 32'h1234_5678,  32'hDEAD_BEEF};
    tv[2] = '{1'b0, 1'b1, 32'h0000_040C, 32'h0,          32'h1234_5678};
    tv[3] = '{1'b1, 1'b1, 32'h0000_0400, 32'h0000_0001,  32'h1234_5678};
    tv[4] = '{1'b0, 1'b1, 32'h0000_040F, 32'h0,          32'h1234_5678};

    for (int i = 0; i < (1<<18); i++) mem[i] = 16'h0;
    mem[{widx(32'h408), 1'b0}] = 16'hBEEF;
    mem[{widx(32'h408), 1'b1}] = 16'hDEAD;
    mem[{widx(32'h400), 1'b1}] = 16'hFFFF;
    mem[{widx(32'h418), 1'b1}] = 16'h7777;

    rst = 0; mem_r_en = 0; mem_w_en = 0; addr = 0; wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready_strobes", {29'd0, ready, sram_we_n, sram_oe_n}, 32'd7);
    chk("rst_addr", {14'd0, sram_addr}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1;
    @(negedge clk);

    // Table of single accesses.
    for (int i = 0; i < 5; i++) begin
      wi = widx(tv[i].a);
      run_access(tv[i].w, tv[i].r, tv[i].a, tv[i].wd, 1'b0,
                 low, lo_n, hi_n, lo_a, hi_a, oe_bad, rd);
      chk($sformatf("v%0d_rdata", i), rd, tv[i].exp_rd);
      chk($sformatf("v%0d_low", i), low, 1 + 2*W);
      chk($sformatf("v%0d_phases", i), {lo_n[15:0], hi_n[15:0]}, {16'(W), 16'(W)});
      chk($sformatf("v%0d_lo_addr", i), {14'd0, lo_a}, {14'd0, wi, 1'b0});
      chk($sformatf("v%0d_hi_addr", i), {14'd0, hi_a}, {14'd0, wi, 1'b1});
      if (tv[i].w) begin
        chk($sformatf("v%0d_no_oe", i), {31'd0, oe_bad}, 32'd0);
        chk($sformatf("v%0d_mem", i), {mem[{wi, 1'b1}], mem[{wi, 1'b0}]}, tv[i].wd);
      end
      @(negedge clk);
    end

    // Idle bus for 10 cycles.
    saved = rdata;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_ready_strobes", {29'd0, ready, sram_we_n, sram_oe_n}, 32'd7);
      chk("idle_rdata", rdata, saved);
    end

    // Store then load back-to-back: the load's low window includes one IDLE cycle.
    run_access(1'b1, 1'b0, 32'h410, 32'hCAFE_F00D, 1'b1,
               low, lo_n, hi_n, lo_a, hi_a, oe_bad, rd);
    chk("b2b_wr_low", low, 1 + 2*W);
    run_access(1'b0, 1'b1, 32'h410, 32'h0, 1'b0,
               low, lo_n, hi_n, lo_a, hi_a, oe_bad, rd);
    chk("b2b_rd_low", low, 1 + 2*W);
    chk("b2b_rdata", rd, 32'hCAFE_F00D);
    @(negedge clk);

    // Reset during WR_HI, before any write edge of the high half.
    mem_w_en = 1; mem_r_en = 0; addr = 32'h418; wdata = 32'hAAAA_5555;
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (!sram_we_n && sram_addr[0]) hit = 1;
    end
    chk("rst_mid_reached_wr_hi", {31'd0, hit}, 32'd1);
    rst = 0;
    #1;
    chk("rst_mid_strobes", {30'd0, sram_we_n, sram_oe_n}, 32'd3);
    chk("rst_mid_addr", {14'd0, sram_addr}, 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    mem_w_en = 0;
    #1;
    chk("rst_mid_idle_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    rst = 1;
    repeat (4) @(negedge clk);
    chk("rst_mid_hi_kept", {16'd0, mem[{widx(32'h418), 1'b1}]}, 32'h7777);
    chk("rst_mid_lo_done", {16'd0, mem[{widx(32'h418), 1'b0}]}, 32'h5555);
    chk("rst_mid_after_idle", {29'd0, ready, sram_we_n, sram_oe_n}, 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
